fp_mul_sequencer: RTL

//  Sequencer for the FP32 multiply path. Accepts FP32 operand pairs over a valid/ready handshake.

---
 rtl/fp_mul_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fp_mul_sequencer.sv
// fp_mul_sequencer: FP32 multiply sequencer around an external 24-bit mantissa
// multiplier. Special operands (zero/denormal, inf, NaN) are resolved without
// starting the multiplier. Optional WAIT watchdog enabled by FPM_TIMEOUT_EN.
module fp_mul_sequencer #(
  parameter int BIAS        = 127,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [23:0] mant_a,
  output logic [23:0] mant_b,
  output logic        mul_rstn,
  input  logic        mul_ready,
  input  logic        mul_norm,
  input  logic [22:0] mul_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy,
  output logic        err
);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, PACK, HOLD} state_t;
  state_t state, nxt;

  // operand classification straight off the input bus
  logic za, zb, ia, ib, na, nb, special;
  assign za = (a[30:23] == 8'h00);
  assign zb = (b[30:23] == 8'h00);
  assign ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
  assign ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
  assign na = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  assign nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
  assign special = za | zb | ia | ib | na | nb;

  logic       s_q, nan_q, inf_q, zero_q, norm_q, to_q;
  logic [7:0] ea_q, eb_q;
  logic [22:0] frac_q;
  logic       tmo;

`ifdef FPM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wcnt;
  logic          err_q;
  assign tmo = (state == WAIT) && !mul_ready && (wcnt == CW'(TIMEOUT_CYC - 1));
  assign err = err_q;
  // watchdog counter restarts on each WAIT entry; err pulses on the expiry edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      wcnt  <= (state == WAIT) ? wcnt + 1'b1 : '0;
      err_q <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = special ? PACK : LAUNCH;
      LAUNCH:  nxt = WAIT;
      WAIT:    if (mul_ready || tmo) nxt = PACK;
      PACK:    nxt = HOLD;
      HOLD:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // exponent math: ea + eb - BIAS + norm as a signed 10-bit value
  logic [9:0]  e_sum;
  logic [31:0] pack_res;
  always_comb begin
    e_sum = {2'b00, ea_q} + {2'b00, eb_q} - 10'(BIAS) + {9'd0, norm_q};
    pack_res = {s_q, e_sum[7:0], frac_q};
    if (to_q || nan_q)                        pack_res = QNAN;
    else if (inf_q)                           pack_res = {s_q, 8'hFF, 23'h0};
    else if (zero_q)                          pack_res = {s_q, 31'h0};
    else if (!e_sum[9] && e_sum >= 10'd255)   pack_res = {s_q, 8'hFF, 23'h0};
    else if (e_sum[9] || e_sum == 10'd0)      pack_res = {s_q, 31'h0};
  end

  // state, operand capture, multiplier control and result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      s_q      <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      norm_q   <= 1'b0;
      frac_q   <= '0;
      to_q     <= 1'b0;
      mant_a   <= '0;
      mant_b   <= '0;
      mul_rstn <= 1'b0;
      result   <= '0;
    end else begin
      state    <= nxt;
      mul_rstn <= (nxt == WAIT);
      if (state == IDLE && in_valid) begin
        s_q    <= a[31] ^ b[31];
        ea_q   <= a[30:23];
        eb_q   <= b[30:23];
        nan_q  <= na | nb | (za & ib) | (ia & zb);
        inf_q  <= ia | ib;
        zero_q <= za | zb;
        norm_q <= 1'b0;
        frac_q <= '0;
        to_q   <= 1'b0;
        if (!special) begin
          mant_a <= {1'b1, a[22:0]};
          mant_b <= {1'b1, b[22:0]};
        end
      end
      if (state == WAIT) begin
        if (mul_ready) begin
          norm_q <= mul_norm;
          frac_q <= mul_frac;
        end else if (tmo) begin
          to_q <= 1'b1;
        end
      end
      if (state == PACK) result <= pack_res;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
endmodule
